// File: rtl/ucode_sequencer.sv
// Microcode sequencer: fetches control words, executes jump/loop/DJNZ/halt locally
// and hands PIM words to the decoder via valid/ready. Optional: UCODE_SEQ_TRAP_EN.
module ucode_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              trap,
    output logic              cm_rd_en,
    output logic [ADDR_W-1:0] cm_addr,
    input  logic [15:0]       cm_rdata,
    output logic [3:0]        CW_opcode,
    output logic              pim_en,
    output logic              pim_valid,
    input  logic              pim_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_JMP  = 4'd1,
        OP_LOOP = 4'd2,
        OP_DJNZ = 4'd3,
        OP_HALT = 4'd4
    } ctl_op_e;

    localparam logic [ADDR_W-1:0] PC_ONE  = 1;
    localparam logic [10:0]       CNT_ONE = 11'd1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
`ifdef UCODE_SEQ_TRAP_EN
    logic              trap_q, trap_d;
`endif

    assign target = cm_rdata[ADDR_W-1:0];
    assign pc_inc = pc_q + PC_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
`ifdef UCODE_SEQ_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
`ifdef UCODE_SEQ_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
`ifdef UCODE_SEQ_TRAP_EN
        trap_d  = trap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = start_addr;
                    cnt_d   = '0;
`ifdef UCODE_SEQ_TRAP_EN
                    trap_d  = 1'b0;
`endif
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (cm_rdata[15]) begin
                    op_d    = cm_rdata[14:11];
                    pc_d    = pc_inc;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    case (cm_rdata[14:11])
                        OP_NOP:  ;
                        OP_JMP:  pc_d = target;
                        OP_LOOP: cnt_d = cm_rdata[10:0];
                        OP_DJNZ: begin
                            // Branch decision uses the decremented count, so cnt==1 falls through.
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - CNT_ONE;
                                if (cnt_q != CNT_ONE) pc_d = target;
                            end
                        end
                        OP_HALT: begin
                            state_d = S_DONE;
                            pc_d    = pc_q;
                        end
                        default: begin
`ifdef UCODE_SEQ_TRAP_EN
                            trap_d  = 1'b1;
                            state_d = S_DONE;
                            pc_d    = pc_q;
`endif
                        end
                    endcase
                end
            end
            S_ISSUE: if (pim_ready) state_d = S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE);
        done      = (state_q == S_DONE);
        cm_rd_en  = (state_q == S_FETCH);
        cm_addr   = pc_q;
        pim_valid = (state_q == S_ISSUE);
        pim_en    = (state_q == S_ISSUE);
        CW_opcode = (state_q == S_ISSUE) ? op_q : 4'd0;
`ifdef UCODE_SEQ_TRAP_EN
        trap      = trap_q;
`else
        trap      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: expected PIM handshakes and done pulses are
// queued per program and matched against the DUT; timing points checked directly.
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  start_addr;
    logic        busy, done, trap, cm_rd_en;
    logic [7:0]  cm_addr;
    logic [15:0] cm_rdata;
    logic [3:0]  CW_opcode;
    logic        pim_en, pim_valid, pim_ready;

    logic [15:0] mem [256];
    int          exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    ucode_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .busy(busy), .done(done), .trap(trap), .cm_rd_en(cm_rd_en),
        .cm_addr(cm_addr), .cm_rdata(cm_rdata), .CW_opcode(CW_opcode),
        .pim_en(pim_en), .pim_valid(pim_valid), .pim_ready(pim_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cm_rd_en) cm_rdata <= mem[cm_addr];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event codes: 100+opcode for a PIM handshake, 200+trap for a done pulse.
    always @(negedge clk) begin
        int obs, exp;
        if (!rst && ((pim_valid && pim_ready) || done)) begin
            obs = done ? 200 + int'(trap) : 100 + int'(CW_opcode);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            check("event", obs, exp);
            if (pim_valid) check("pim_en", int'(pim_en), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pim(input int op);
        return 16'h8000 | 16'(op << 11);
    endfunction

    function automatic logic [15:0] ctl(input int op, input int field);
        return 16'((op << 11) | field);
    endfunction

    task automatic kick(input logic [7:0] addr);
        start      = 1'b1;
        start_addr = addr;
        step();
        start      = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int found = 0;
        for (int i = 0; i < budget && found == 0; i++) begin
            step();
            if (done) found = 1;
        end
        check(tag, found, 1);
        check({tag, "_busy"}, int'(busy), 0);
        step();
        check({tag, "_done_1cyc"}, int'(done), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = pim(15);
        rst = 1'b1; start = 1'b0; start_addr = '0; pim_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_trap", int'(trap), 0);
        check("rst_rden", int'(cm_rd_en), 0);
        check("rst_addr", int'(cm_addr), 0);
        check("rst_op", int'(CW_opcode), 0);
        check("rst_en", int'(pim_en), 0);
        check("rst_valid", int'(pim_valid), 0);

        // Basic PIM + HALT with latency
        mem[8'h10] = pim(5); mem[8'h11] = ctl(4, 0);
        pim_ready = 1'b1;
        exp_q.push_back(105); exp_q.push_back(200);
        kick(8'h10);
        check("t1_busy", int'(busy), 1);
        check("t1_rden", int'(cm_rd_en), 1);
        check("t1_addr", int'(cm_addr), 8'h10);
        n = 0;
        while (!done && n < 20) begin step(); n++; end
        check("t1_latency", n, 5);
        check("t1_busy_at_done", int'(busy), 0);
        step();
        check("t1_done_pulse", int'(done), 0);

        // LOOP 3 / DJNZ
        mem[8'h20] = ctl(2, 3); mem[8'h21] = pim(2);
        mem[8'h22] = ctl(3, 8'h21); mem[8'h23] = ctl(4, 0);
        repeat (3) exp_q.push_back(102);
        exp_q.push_back(200);
        kick(8'h20);
        run_until_done("t2_done", 100);

        // DJNZ with cnt==0 after start falls through
        mem[8'h70] = ctl(3, 8'h70); mem[8'h71] = ctl(4, 0);
        exp_q.push_back(200);
        kick(8'h70);
        run_until_done("t2b_done", 40);

        // Backpressure: ready low for 4 ISSUE cycles
        mem[8'h30] = pim(9); mem[8'h31] = ctl(4, 0);
        pim_ready = 1'b0;
        exp_q.push_back(109); exp_q.push_back(200);
        kick(8'h30);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            check("t3_valid", int'(pim_valid), 1);
            check("t3_en", int'(pim_en), 1);
            check("t3_op", int'(CW_opcode), 9);
            check("t3_nofetch", int'(cm_rd_en), 0);
            if (i == 4) pim_ready = 1'b1;
            step();
        end
        check("t3_fetch", int'(cm_rd_en), 1);
        check("t3_addr", int'(cm_addr), 8'h31);
        check("t3_valid_off", int'(pim_valid), 0);
        run_until_done("t3_done", 20);

        // PC wrap and ignored mid-run start
        mem[8'hFF] = ctl(0, 0); mem[8'h00] = ctl(4, 0); mem[8'h40] = pim(1);
        exp_q.push_back(200);
        kick(8'hFF);
        check("t4_addr", int'(cm_addr), 8'hFF);
        step();
        kick(8'h40);
        check("t4_wrap", int'(cm_addr), 0);
        check("t4_rden", int'(cm_rd_en), 1);
        run_until_done("t4_done", 20);
        step();
        check("t4_no_queue", int'(busy), 0);

        // Reset during ISSUE
        mem[8'h50] = pim(3);
        pim_ready = 1'b0;
        kick(8'h50);
        step(); step();
        check("t5_issue", int'(pim_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_valid", int'(pim_valid), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_en", int'(pim_en), 0);
        check("t5_op", int'(CW_opcode), 0);
        repeat (4) begin step(); check("t5_nodone", int'(done), 0); end
        pim_ready = 1'b1;

        // Opcode 7
        mem[8'h60] = ctl(7, 0); mem[8'h61] = ctl(4, 0);
`ifdef UCODE_SEQ_TRAP_EN
        exp_q.push_back(201);
        kick(8'h60);
        run_until_done("t6_done", 20);
        check("t6_trap_sticky", int'(trap), 1);
        mem[8'h62] = ctl(4, 0);
        exp_q.push_back(200);
        kick(8'h62);
        check("t6_trap_clear", int'(trap), 0);
        run_until_done("t6b_done", 20);
`else
        exp_q.push_back(200);
        kick(8'h60);
        step(); step();
        check("t6_nop_fetch", int'(cm_addr), 8'h61);
        run_until_done("t6_done", 20);
        check("t6_trap", int'(trap), 0);
`endif

        step();
        check("leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
